// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data RAM
// CORE (0) and DMA (1) share one RAM; each granted access takes IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADD_W     = 10,
    parameter int PRIO_MODE = 0
) (
    input  logic              CLK,
    input  logic              RSTa,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADD_W-1:0]  ADDR0,
    input  logic [ADD_W-1:0]  ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADD_W-1:0]  RAM_ADDRESS,
    output logic [DATA_W-1:0] RAM_DATAIN,
    output logic              RAM_WR,
    input  logic [DATA_W-1:0] RAM_DATAOUT
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   gnt;
    logic   last_gnt;
    logic   win;
    logic   load;
    logic   capture;
    logic   release_ack;

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ0 || REQ1) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        win         = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        release_ack = 1'b0;
        if (REQ0 && REQ1) begin
            win = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt;
        end else begin
            win = REQ1;
        end
        case (state)
            IDLE:    load        = REQ0 || REQ1;
            ACCESS:  capture     = 1'b1;
            RESP:    release_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            gnt         <= 1'b0;
            last_gnt    <= 1'b1;
            ACK0        <= 1'b0;
            ACK1        <= 1'b0;
            RDATA       <= '0;
            RAM_ADDRESS <= '0;
            RAM_DATAIN  <= '0;
            RAM_WR      <= 1'b0;
        end else begin
            if (load) begin
                gnt         <= win;
                RAM_ADDRESS <= win ? ADDR1  : ADDR0;
                RAM_DATAIN  <= win ? WDATA1 : WDATA0;
                RAM_WR      <= win ? WE1    : WE0;
            end
            if (capture) begin
                if (!RAM_WR) RDATA <= RAM_DATAOUT;
                RAM_WR   <= 1'b0;
                ACK0     <= ~gnt;
                ACK1     <= gnt;
                last_gnt <= gnt;
            end
            if (release_ack) begin
                ACK0 <= 1'b0;
                ACK1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Index 0 is a round-robin instance, index 1 a fixed-priority instance.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst, req0, req1, we0, we1;
    logic [AW-1:0] addr0 [2];
    logic [AW-1:0] addr1 [2];
    logic [DW-1:0] wdata0 [2];
    logic [DW-1:0] wdata1 [2];
    logic [1:0]    ack0, ack1, ram_wr;
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] ram_din [2];
    logic [DW-1:0] ram_dout [2];
    logic [AW-1:0] ram_addr [2];

    logic [DW-1:0] mem [2][1024];
    logic [DW-1:0] ref_mem [2][1024];
    logic [DW-1:0] exp_rdata [2];
    int            last [2];
    int            checks = 0;
    int            failures = 0;

    dmem_arbiter #(.DATA_W(DW), .ADD_W(AW), .PRIO_MODE(0)) u_rr (
        .CLK(clk), .RSTa(rst[0]), .REQ0(req0[0]), .REQ1(req1[0]),
        .WE0(we0[0]), .WE1(we1[0]), .ADDR0(addr0[0]), .ADDR1(addr1[0]),
        .WDATA0(wdata0[0]), .WDATA1(wdata1[0]), .ACK0(ack0[0]), .ACK1(ack1[0]),
        .RDATA(rdata[0]), .RAM_ADDRESS(ram_addr[0]), .RAM_DATAIN(ram_din[0]),
        .RAM_WR(ram_wr[0]), .RAM_DATAOUT(ram_dout[0])
    );

    dmem_arbiter #(.DATA_W(DW), .ADD_W(AW), .PRIO_MODE(1)) u_fp (
        .CLK(clk), .RSTa(rst[1]), .REQ0(req0[1]), .REQ1(req1[1]),
        .WE0(we0[1]), .WE1(we1[1]), .ADDR0(addr0[1]), .ADDR1(addr1[1]),
        .WDATA0(wdata0[1]), .WDATA1(wdata1[1]), .ACK0(ack0[1]), .ACK1(ack1[1]),
        .RDATA(rdata[1]), .RAM_ADDRESS(ram_addr[1]), .RAM_DATAIN(ram_din[1]),
        .RAM_WR(ram_wr[1]), .RAM_DATAOUT(ram_dout[1])
    );

    // Behavioural RAMs: write on the edge closing a cycle with RAM_WR high, async read.
    always @(posedge clk) if (ram_wr[0]) mem[0][ram_addr[0]] <= ram_din[0];
    always @(posedge clk) if (ram_wr[1]) mem[1][ram_addr[1]] <= ram_din[1];
    assign ram_dout[0] = mem[0][ram_addr[0]];
    assign ram_dout[1] = mem[1][ram_addr[1]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input int r, input logic en, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin
            req0[m] = en; we0[m] = we; addr0[m] = a; wdata0[m] = d;
        end else begin
            req1[m] = en; we1[m] = we; addr1[m] = a; wdata1[m] = d;
        end
    endtask

    task automatic do_reset(input int m);
        req0[m] = 1'b0;
        req1[m] = 1'b0;
        rst[m]  = 1'b1;
        tick();
        tick();
        rst[m]       = 1'b0;
        last[m]      = 1;
        exp_rdata[m] = '0;
    endtask

    // Runs one whole transaction from IDLE and checks it against the arbitration rules.
    task automatic txn(input int m, output int w);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (req0[m] && req1[m]) w = (m == 1) ? 0 : (last[m] == 1 ? 0 : 1);
        else                    w = req1[m] ? 1 : 0;
        we = (w == 1) ? we1[m]    : we0[m];
        a  = (w == 1) ? addr1[m]  : addr0[m];
        d  = (w == 1) ? wdata1[m] : wdata0[m];
        tick();
        chk("access_wr", ram_wr[m], we);
        chk("access_addr", ram_addr[m], a);
        if (we) chk("access_din", ram_din[m], d);
        chk("access_ack0", ack0[m], 0);
        chk("access_ack1", ack1[m], 0);
        tick();
        if (!we) exp_rdata[m] = ref_mem[m][a];
        chk("resp_ack0", ack0[m], w == 0);
        chk("resp_ack1", ack1[m], w == 1);
        chk("resp_rdata", rdata[m], exp_rdata[m]);
        chk("resp_wr", ram_wr[m], 0);
        tick();
        chk("idle_ack0", ack0[m], 0);
        chk("idle_ack1", ack1[m], 0);
        chk("idle_wr", ram_wr[m], 0);
        if (we) begin
            ref_mem[m][a] = d;
            chk("ram_written", mem[m][a], d);
        end
        last[m] = w;
    endtask

    initial begin
        int            w;
        logic [DW-1:0] saved;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1024; i++) begin
                mem[m][i]     = $urandom;
                ref_mem[m][i] = mem[m][i];
            end
            addr0[m] = '0; addr1[m] = '0; wdata0[m] = '0; wdata1[m] = '0;
        end
        we0 = '0; we1 = '0; req0 = '0; req1 = '0;
        rst = 2'b11;
        tick();
        rst = 2'b00;
        last[0] = 1; last[1] = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;

        for (int m = 0; m < 2; m++) begin
            chk("rst_ack0", ack0[m], 0);
            chk("rst_ack1", ack1[m], 0);
            chk("rst_wr", ram_wr[m], 0);
            chk("rst_addr", ram_addr[m], 0);
            chk("rst_din", ram_din[m], 0);
            chk("rst_rdata", rdata[m], 0);
        end

        for (int c = 0; c < 10; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk("idle_stab_wr", ram_wr[m], 0);
                chk("idle_stab_ack", {ack1[m], ack0[m]}, 0);
                chk("idle_stab_rdata", rdata[m], 0);
            end
        end

        // CORE write then read back.
        set_req(0, 0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
        txn(0, w);
        chk("core_wr_winner", w, 0);
        set_req(0, 0, 1'b1, 1'b0, 10'h005, 32'h0);
        txn(0, w);
        req0[0] = 1'b0;
        chk("core_readback", rdata[0], 32'hDEADBEEF);

        // Round-robin saturation from reset.
        do_reset(0);
        set_req(0, 0, 1'b1, 1'b0, 10'h021, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 10'h042, 32'h0);
        for (int i = 0; i < 4; i++) begin
            txn(0, w);
            chk("rr_order", w, i % 2);
        end
        req0[0] = 1'b0; req1[0] = 1'b0;

        // Fixed priority: CORE wins while it requests.
        set_req(1, 0, 1'b1, 1'b0, 10'h100, 32'h0);
        set_req(1, 1, 1'b1, 1'b0, 10'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            txn(1, w);
            chk("fp_core_wins", w, 0);
        end
        req0[1] = 1'b0;
        txn(1, w);
        chk("fp_dma_after", w, 1);
        req1[1] = 1'b0;

        // DMA read of the top address held through RESP.
        set_req(0, 1, 1'b1, 1'b0, 10'h3FF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            txn(0, w);
            chk("dma_hold_winner", w, 1);
        end
        req1[0] = 1'b0;

        // Reset during ACCESS of a CORE write: the write must not land.
        set_req(0, 0, 1'b1, 1'b0, 10'h011, 32'h0);
        txn(0, w);
        set_req(0, 0, 1'b1, 1'b1, 10'h010, 32'h0000_1234);
        saved = mem[0][16];
        tick();
        chk("mid_wr_access", ram_wr[0], 1);
        rst[0] = 1'b1;
        #1;
        chk("mid_rst_ack", {ack1[0], ack0[0]}, 0);
        chk("mid_rst_wr", ram_wr[0], 0);
        chk("mid_rst_addr", ram_addr[0], 0);
        chk("mid_rst_din", ram_din[0], 0);
        chk("mid_rst_rdata", rdata[0], 0);
        req0[0] = 1'b0;
        #2;
        rst[0] = 1'b0;
        last[0] = 1;
        exp_rdata[0] = '0;
        tick();
        chk("mid_rst_mem", mem[0][16], saved);
        chk("mid_rst_ack0", ack0[0], 0);
        set_req(0, 0, 1'b1, 1'b0, 10'h030, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 10'h031, 32'h0);
        txn(0, w);
        chk("mid_rst_tie_core", w, 0);
        req0[0] = 1'b0; req1[0] = 1'b0;

        // Randomised traffic; the loser keeps its request stable.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 30; k++) begin
                if (!req0[m] && $urandom_range(3) != 0)
                    set_req(m, 0, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
                if (!req1[m] && $urandom_range(3) != 0)
                    set_req(m, 1, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
                if (!req0[m] && !req1[m])
                    set_req(m, 0, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
                txn(m, w);
                if (w == 0) req0[m] = 1'b0;
                else        req1[m] = 1'b0;
            end
            req0[m] = 1'b0; req1[m] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
